// File: rtl/card_draw_arbiter_pkg.sv
// card_draw_arbiter_pkg
//   Shared definitions for the card draw arbiter: FSM state encoding, rank bounds,
//   per-rank full-shoe counts and the shoe size helper.
//   Optional feature macro used by the importing modules: DRAW_ARB_DECK_TRACK_EN.
//   Ports: none (package).
package card_draw_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDraw    = 2'd1,
    StAck     = 2'd2,
    StShuffle = 2'd3
  } draw_state_e;

  localparam logic [3:0]  RANK_MIN       = 4'd1;
  localparam logic [3:0]  RANK_MAX       = 4'd10;
  localparam logic [3:0]  RANK_ACE       = 4'd1;
  localparam int unsigned NUM_RANKS      = 10;
  // Ranks 1..9 have four cards per deck; rank 10 folds ten, jack, queen and king.
  localparam int unsigned PIP_PER_DECK   = 4;
  localparam int unsigned TEN_PER_DECK   = 16;
  localparam int unsigned CARDS_PER_DECK = 52;

  function automatic logic [8:0] shoe_size(input int unsigned num_decks);
    return 9'(CARDS_PER_DECK * num_decks);
  endfunction

  function automatic logic [7:0] full_count(input int unsigned rank,
                                            input int unsigned num_decks);
    return (rank == NUM_RANKS) ? 8'(TEN_PER_DECK * num_decks) : 8'(PIP_PER_DECK * num_decks);
  endfunction

endpackage

// File: rtl/card_draw_arbiter_deck_counter.sv
// card_draw_arbiter_deck_counter
//   Finite-shoe bookkeeping: one count register per rank, decrement on a draw, full reload
//   on shuffle, running cards_left total, per-rank availability and lowest-available-rank
//   encoder. Only instantiated when DRAW_ARB_DECK_TRACK_EN is defined.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset (counts come up full)
//     dec          remove one card of dec_rank (caller guarantees that rank is available)
//     dec_rank     rank being drawn, 1..10
//     reload       refill every rank (wins over dec)
//     rank_avail   bit i set when rank i+1 still has cards
//     lowest_rank  lowest rank with a nonzero count (ace when shoe is empty)
//     cards_left   cards remaining in the shoe
//     low_deck     registered cards_left < LOW_THRESH
module card_draw_arbiter_deck_counter
  import card_draw_arbiter_pkg::*;
#(
  parameter int unsigned NUM_DECKS  = 1,
  parameter int unsigned LOW_THRESH = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec,
  input  logic [3:0]           dec_rank,
  input  logic                 reload,
  output logic [NUM_RANKS-1:0] rank_avail,
  output logic [3:0]           lowest_rank,
  output logic [8:0]           cards_left,
  output logic                 low_deck
);

  logic [7:0] count_q [NUM_RANKS];
  logic [7:0] count_d [NUM_RANKS];
  logic [8:0] cards_left_q, cards_left_d;
  logic       low_deck_q;

  always_comb begin
    count_d      = count_q;
    cards_left_d = cards_left_q;
    if (reload) begin
      for (int unsigned i = 0; i < NUM_RANKS; i++) begin
        count_d[i] = full_count(i + 1, NUM_DECKS);
      end
      cards_left_d = shoe_size(NUM_DECKS);
    end else if (dec) begin
      for (int unsigned i = 0; i < NUM_RANKS; i++) begin
        if (dec_rank == 4'(i + 1)) begin
          count_d[i] = count_q[i] - 8'd1;
        end
      end
      cards_left_d = cards_left_q - 9'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_RANKS; i++) begin
        count_q[i] <= full_count(i + 1, NUM_DECKS);
      end
      cards_left_q <= shoe_size(NUM_DECKS);
      low_deck_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      cards_left_q <= cards_left_d;
      // Computed from the next value so low_deck lines up with cards_left.
      low_deck_q   <= (32'(cards_left_d) < LOW_THRESH);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_RANKS; i++) begin
      rank_avail[i] = (count_q[i] != 8'd0);
    end
  end

  // Scan from the top so the last hit is the lowest available rank.
  always_comb begin
    lowest_rank = RANK_ACE;
    for (int i = int'(NUM_RANKS) - 1; i >= 0; i--) begin
      if (rank_avail[i]) begin
        lowest_rank = 4'(i + 1);
      end
    end
  end

  assign cards_left = cards_left_q;
  assign low_deck   = low_deck_q;

endmodule

// File: rtl/card_draw_arbiter.sv
// card_draw_arbiter
//   Shares card_rng between the player (id 0) and dealer (id 1) draw paths of the blackjack
//   FSM. Round-robin arbitration, req/ack handshake, rejection of out-of-range or exhausted
//   ranks with a bounded retry and deterministic fallback, and shuffle handling.
//   Macro DRAW_ARB_DECK_TRACK_EN: defined -> finite shoe with per-rank counts and automatic
//   reshuffle when empty; undefined -> infinite deck, cards_left fixed, low_deck low.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset
//     rng_value     raw RNG sample, new value every cycle
//     req           level request per requester, held until ack
//     shuffle_req   one-cycle pulse asking for a shoe refill
//     ack           one-cycle pulse, card_out/ack_id valid
//     ack_id        requester served by this ack
//     card_out      drawn rank 1..10
//     cards_left    cards remaining in the shoe
//     low_deck      cards_left < LOW_THRESH
//     shuffle_done  one-cycle pulse after a refill
//     busy          FSM not idle
module card_draw_arbiter
  import card_draw_arbiter_pkg::*;
#(
  parameter int unsigned NUM_DECKS  = 1,
  parameter int unsigned LOW_THRESH = 15,
  parameter int unsigned MAX_RETRY  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rng_value,
  input  logic [1:0] req,
  input  logic       shuffle_req,
  output logic       ack,
  output logic       ack_id,
  output logic [3:0] card_out,
  output logic [8:0] cards_left,
  output logic       low_deck,
  output logic       shuffle_done,
  output logic       busy
);

  draw_state_e state;
  logic        gid;
  logic        last_id;
  logic        shuffle_pend;
  logic [3:0]  retry;

  logic        rng_in_range;
  logic        rng_ok;
  logic        take;
  logic        next_gid;
  logic        shoe_empty;
  logic [3:0]  fallback_rank;
  logic [3:0]  draw_rank;

  assign rng_in_range = (rng_value >= RANK_MIN) && (rng_value <= RANK_MAX);

`ifdef DRAW_ARB_DECK_TRACK_EN
  logic [NUM_RANKS-1:0] rank_avail;
  logic                 rng_avail;

  always_comb begin
    rng_avail = 1'b0;
    for (int unsigned i = 0; i < NUM_RANKS; i++) begin
      if (rng_value == 4'(i + 1)) begin
        rng_avail = rank_avail[i];
      end
    end
  end

  assign rng_ok     = rng_in_range && rng_avail;
  assign shoe_empty = (cards_left == 9'd0);

  card_draw_arbiter_deck_counter #(
    .NUM_DECKS  (NUM_DECKS),
    .LOW_THRESH (LOW_THRESH)
  ) u_deck_counter (
    .clk         (clk),
    .reset       (reset),
    .dec         (take),
    .dec_rank    (draw_rank),
    .reload      (state == StShuffle),
    .rank_avail  (rank_avail),
    .lowest_rank (fallback_rank),
    .cards_left  (cards_left),
    .low_deck    (low_deck)
  );
`else
  assign rng_ok        = rng_in_range;
  assign shoe_empty    = 1'b0;
  assign fallback_rank = RANK_ACE;
  assign cards_left    = shoe_size(NUM_DECKS);
  assign low_deck      = 1'b0;
`endif

  // A draw completes on a good sample, or on the fallback once the retry budget is spent.
  assign take      = (state == StDraw) && (rng_ok || (retry == 4'(MAX_RETRY)));
  assign draw_rank = rng_ok ? rng_value : fallback_rank;

  always_comb begin
    case (req)
      2'b01:   next_gid = 1'b0;
      2'b10:   next_gid = 1'b1;
      default: next_gid = ~last_id;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      ack          <= 1'b0;
      ack_id       <= 1'b0;
      card_out     <= 4'd0;
      shuffle_done <= 1'b0;
      busy         <= 1'b0;
      gid          <= 1'b0;
      last_id      <= 1'b1;
      shuffle_pend <= 1'b0;
      retry        <= 4'd0;
    end else begin
      ack          <= 1'b0;
      shuffle_done <= 1'b0;
      unique case (state)
        StIdle: begin
          // Empty shoe forces a refill; the pending req is served afterwards.
          if (shuffle_pend || shuffle_req || ((req != 2'b00) && shoe_empty)) begin
            state <= StShuffle;
            busy  <= 1'b1;
          end else if (req != 2'b00) begin
            gid   <= next_gid;
            state <= StDraw;
            busy  <= 1'b1;
          end
        end
        StDraw: begin
          if (shuffle_req) begin
            shuffle_pend <= 1'b1;
          end
          if (take) begin
            card_out <= draw_rank;
            last_id  <= gid;
            ack      <= 1'b1;
            ack_id   <= gid;
            retry    <= 4'd0;
            state    <= StAck;
          end else begin
            retry <= retry + 4'd1;
          end
        end
        StAck: begin
          if (shuffle_req) begin
            shuffle_pend <= 1'b1;
          end
          state <= StIdle;
          busy  <= 1'b0;
        end
        StShuffle: begin
          shuffle_pend <= 1'b0;
          shuffle_done <= 1'b1;
          state        <= StIdle;
          busy         <= 1'b0;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_draw_arbiter.sv
module tb_card_draw_arbiter;

  localparam int ND         = 1;
  localparam int SHOE       = 52 * ND;
  localparam int LOW_THRESH = 15;
  localparam int MAX_RETRY  = 7;
`ifdef DRAW_ARB_DECK_TRACK_EN
  localparam bit DECK = 1'b1;
`else
  localparam bit DECK = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] rng_value;
  logic [1:0] req;
  logic       shuffle_req;
  logic       ack;
  logic       ack_id;
  logic [3:0] card_out;
  logic [8:0] cards_left;
  logic       low_deck;
  logic       shuffle_done;
  logic       busy;

  card_draw_arbiter #(
    .NUM_DECKS  (ND),
    .LOW_THRESH (LOW_THRESH),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rng_value    (rng_value),
    .req          (req),
    .shuffle_req  (shuffle_req),
    .ack          (ack),
    .ack_id       (ack_id),
    .card_out     (card_out),
    .cards_left   (cards_left),
    .low_deck     (low_deck),
    .shuffle_done (shuffle_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int card;
    int left;
    int low;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_cnt[11];
  int   m_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 1; r <= 9; r++) m_cnt[r] = 4 * ND;
    m_cnt[10] = 16 * ND;
    m_left = SHOE;
  endfunction

  function automatic bit m_avail(input int r);
    if (r < 1 || r > 10) return 1'b0;
    return !DECK || (m_cnt[r] > 0);
  endfunction

  function automatic int m_lowest();
    if (!DECK) return 1;
    for (int r = 1; r <= 10; r++) if (m_cnt[r] > 0) return r;
    return 1;
  endfunction

  function automatic int m_highest();
    for (int r = 10; r >= 1; r--) if (m_cnt[r] > 0) return r;
    return 1;
  endfunction

  // Predict the outcome of a draw whose DRAW state samples rng for the whole wait.
  task automatic expect_draw(input int id, input int rng, input int lat_base);
    exp_t e;
    bit   hit;
    hit    = m_avail(rng);
    e.id   = id;
    e.card = hit ? rng : m_lowest();
    e.lat  = lat_base + (hit ? 0 : MAX_RETRY);
    if (DECK) begin
      m_cnt[e.card]--;
      m_left--;
    end
    e.left = DECK ? m_left : SHOE;
    e.low  = (DECK && m_left < LOW_THRESH) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  task automatic wait_ack(input string tag, input bit drop);
    exp_t e;
    int   n;
    bit   seen;
    check({tag, " scoreboard entry"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() == 0) return;
    e    = sb_q.pop_front();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < e.lat + 4) begin
      @(negedge clk);
      n++;
      if (ack === 1'b1) seen = 1'b1;
    end
    if (drop) req = 2'b00;
    check({tag, " ack seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, 32'(n), 32'(e.lat));
      check({tag, " ack_id"}, 32'(ack_id), 32'(e.id));
      check({tag, " card_out"}, 32'(card_out), 32'(e.card));
      check({tag, " cards_left"}, 32'(cards_left), 32'(e.left));
      check({tag, " low_deck"}, 32'(low_deck), 32'(e.low));
    end
  endtask

  initial begin
    bit seen;
    int pick;
    bit first;

    reset       = 1'b1;
    req         = 2'b00;
    shuffle_req = 1'b0;
    rng_value   = 4'd0;
    m_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset ack", 32'(ack), 32'd0);
    check("reset ack_id", 32'(ack_id), 32'd0);
    check("reset card_out", 32'(card_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset shuffle_done", 32'(shuffle_done), 32'd0);
    check("reset cards_left", 32'(cards_left), 32'(SHOE));
    check("reset low_deck", 32'(low_deck), 32'd0);
    reset = 1'b0;

    // Single player request, first-try accept
    @(negedge clk);
    req = 2'b01; rng_value = 4'd7;
    expect_draw(0, 7, 2);
    wait_ack("t1 single", 1'b1);
    @(negedge clk);
    check("t1 busy after ack", 32'(busy), 32'd0);

    // Both requesting: round robin from reset, player first
    req = 2'b00; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; m_reset();
    @(negedge clk);
    req = 2'b11; rng_value = 4'd10;
    for (int k = 0; k < 4; k++) begin
      expect_draw(k % 2, 10, (k == 0) ? 2 : 3);
      wait_ack("t2 round robin", k == 3);
    end

    // Rejected samples 0 and 13, then 4 accepted
    @(negedge clk);
    req = 2'b01; rng_value = 4'd0;
    @(negedge clk);
    check("t3 no early ack", 32'(ack), 32'd0);
    @(negedge clk);
    rng_value = 4'd13;
    @(negedge clk);
    rng_value = 4'd4;
    expect_draw(0, 4, 1);
    wait_ack("t3 retry accept", 1'b1);

    // Stuck out of range: fallback after MAX_RETRY rejections
    @(negedge clk);
    req = 2'b01; rng_value = 4'd15;
    expect_draw(0, 15, 2);
    wait_ack("t3 fallback", 1'b1);

    // Same rank five times: exhausts it when the shoe is tracked
    @(negedge clk);
    req = 2'b01; rng_value = 4'd5;
    for (int k = 0; k < 5; k++) begin
      expect_draw(0, 5, (k == 0) ? 2 : 3);
      wait_ack("t4 repeat rank", k == 4);
    end

`ifdef DRAW_ARB_DECK_TRACK_EN
    // Drain the shoe, then a request must refill it before drawing
    @(negedge clk);
    req   = 2'b01;
    first = 1'b1;
    while (m_left > 0) begin
      pick      = m_highest();
      rng_value = 4'(pick);
      expect_draw(0, pick, first ? 2 : 3);
      wait_ack("t4 drain", m_left == 0);
      first = 1'b0;
    end
    check("t4 drained", 32'(cards_left), 32'd0);
    @(negedge clk);
    req = 2'b01; rng_value = 4'd7;
    @(negedge clk);
    check("t4 auto shuffle busy", 32'(busy), 32'd1);
    check("t4 auto shuffle not done yet", 32'(shuffle_done), 32'd0);
    @(negedge clk);
    check("t4 auto shuffle_done", 32'(shuffle_done), 32'd1);
    check("t4 refilled cards_left", 32'(cards_left), 32'(SHOE));
    check("t4 refilled low_deck", 32'(low_deck), 32'd0);
    m_reset();
    expect_draw(0, 7, 2);
    wait_ack("t4 draw after refill", 1'b1);
`endif

    // shuffle_req during DRAW: draw completes, then refill
    @(negedge clk);
    req = 2'b01; rng_value = 4'd15;
    @(negedge clk);
    shuffle_req = 1'b1;
    @(negedge clk);
    shuffle_req = 1'b0; rng_value = 4'd3;
    expect_draw(0, 3, 1);
    wait_ack("t5 draw before shuffle", 1'b1);
    @(negedge clk);
    check("t5 idle busy", 32'(busy), 32'd0);
    check("t5 no done yet", 32'(shuffle_done), 32'd0);
    @(negedge clk);
    check("t5 shuffle busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t5 shuffle_done", 32'(shuffle_done), 32'd1);
    check("t5 cards_left", 32'(cards_left), 32'(SHOE));
    m_reset();
    @(negedge clk);
    check("t5 shuffle_done pulse", 32'(shuffle_done), 32'd0);

    // shuffle_req together with req in IDLE: shuffle first, then the draw
    @(negedge clk);
    req = 2'b01; shuffle_req = 1'b1; rng_value = 4'd6;
    @(negedge clk);
    shuffle_req = 1'b0;
    check("t5b shuffle first busy", 32'(busy), 32'd1);
    check("t5b no ack during shuffle", 32'(ack), 32'd0);
    @(negedge clk);
    check("t5b shuffle_done", 32'(shuffle_done), 32'd1);
    m_reset();
    expect_draw(0, 6, 2);
    wait_ack("t5b draw after shuffle", 1'b1);

    // Reset mid-DRAW: aborts the draw immediately
    @(negedge clk);
    req = 2'b01; rng_value = 4'd15;
    @(negedge clk);
    check("t6 busy in draw", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6 busy async clear", 32'(busy), 32'd0);
    check("t6 ack async clear", 32'(ack), 32'd0);
    check("t6 cards_left async", 32'(cards_left), 32'(SHOE));
    check("t6 card_out async", 32'(card_out), 32'd0);
    req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1'b1;
    end
    check("t6 no ack after reset", 32'(seen), 32'd0);
    check("t6 idle after reset", 32'(busy), 32'd0);

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
